t06_apple_spawner: RTL and testbench

//  Consumer of the 2-bit apple_luck setting chosen in the menu. On each spawn request

---
 rtl/t06_pkg.sv | 42 ++++
 rtl/t06_lfsr16.sv | 20 ++
 rtl/t06_apple_spawner.sv | 124 ++++++++++++
 tb/tb_t06_apple_spawner.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/t06_pkg.sv
// Shared constants for the apple spawner: game states, luck encodings,
// grid defaults, spawner FSM states and the LFSR step function.
package t06_pkg;

    localparam logic [1:0] ST_TITLE = 2'b00;
    localparam logic [1:0] ST_MENU  = 2'b01;
    localparam logic [1:0] ST_PLAY  = 2'b10;
    localparam logic [1:0] ST_OVER  = 2'b11;

    localparam logic [1:0] LUCK_NORMAL  = 2'b00;
    localparam logic [1:0] LUCK_LUCKY   = 2'b01;
    localparam logic [1:0] LUCK_UNLUCKY = 2'b10;

    localparam int GRID_W_DEF = 16;
    localparam int GRID_H_DEF = 12;

    localparam logic [1:0] SP_IDLE  = 2'd0;
    localparam logic [1:0] SP_GEN   = 2'd1;
    localparam logic [1:0] SP_CHECK = 2'd2;

    // Right-shifting Galois form of x^16+x^14+x^13+x^11+1
    localparam logic [15:0] LFSR_TAPS     = 16'hB400;
    localparam logic [15:0] LFSR_SEED_DEF = 16'hACE1;

    function automatic logic [15:0] lfsr16_next(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

    // base + signed 3-bit offset, wrapped once into [0, lim)
    function automatic logic [3:0] wrap_coord(input logic [3:0] base,
                                              input logic [2:0] off,
                                              input int lim);
        int s;
        s = int'(base) + (off[2] ? int'(off) - 8 : int'(off));
        if (s < 0)
            s = s + lim;
        else if (s >= lim)
            s = s - lim;
        return 4'(s);
    endfunction

endpackage

// File: rtl/t06_lfsr16.sv
// Free-running 16-bit Galois LFSR; a zero seed would lock up, so it is remapped.
module t06_lfsr16 import t06_pkg::*; #(
    parameter logic [15:0] SEED = LFSR_SEED_DEF
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] q
);

    localparam logic [15:0] SEED_EFF = (SEED == 16'h0) ? LFSR_SEED_DEF : SEED;

    // Advance every cycle regardless of spawner activity
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            q <= SEED_EFF;
        else
            q <= lfsr16_next(q);
    end

endmodule

// File: rtl/t06_apple_spawner.sv
// Apple placement: on a spawn request during play, draw candidates from the
// LFSR (GEN), test them against the grid, the head and the body store (CHECK),
// and commit the first acceptable one. Luck biases the draw or the filter.
module t06_apple_spawner import t06_pkg::*; #(
    parameter int          GRID_W    = GRID_W_DEF,
    parameter int          GRID_H    = GRID_H_DEF,
    parameter logic [15:0] SEED      = LFSR_SEED_DEF,
    parameter int          MAX_TRIES = 15,
    parameter logic [3:0]  INIT_X    = 4'd8,
    parameter logic [3:0]  INIT_Y    = 4'd6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] state,
    input  logic [1:0] apple_luck,
    input  logic [3:0] head_x,
    input  logic [3:0] head_y,
    input  logic       spawn_req,
    output logic [3:0] occ_x,
    output logic [3:0] occ_y,
    input  logic       occ_hit,
    output logic [3:0] apple_x,
    output logic [3:0] apple_y,
    output logic       apple_valid,
    output logic       busy,
    output logic       spawn_done
);

    localparam int TW = $clog2(MAX_TRIES + 1);

    logic [15:0]   lfsr_q;
    logic          lfsr_unused;
    logic [1:0]    st_q, st_d;
    logic [1:0]    luck_q;
    logic [TW-1:0] tries_q;
    logic [3:0]    cand_x, cand_y;
    logic          in_play, hard_rej, luck_rej, accept, luck_miss;
    int            dx, dy;

    t06_lfsr16 #(.SEED(SEED)) u_lfsr (
        .clk (clk),
        .rst (rst),
        .q   (lfsr_q)
    );

    // Upper LFSR bits only feed the state sequence, not the draw
    assign lfsr_unused = ^lfsr_q[15:8];

    // Candidate draw: raw low bits, or a wrapped -4..+3 window around the head
    always_comb begin
        cand_x = lfsr_q[3:0];
        cand_y = lfsr_q[7:4];
        if (luck_q == LUCK_LUCKY) begin
            cand_x = wrap_coord(head_x, lfsr_q[2:0], GRID_W);
            cand_y = wrap_coord(head_y, lfsr_q[6:4], GRID_H);
        end
    end

    // Candidate judgement and next-state selection
    always_comb begin
        in_play  = (state == ST_PLAY);
        dx       = (occ_x >= head_x) ? int'(occ_x - head_x) : int'(head_x - occ_x);
        dy       = (occ_y >= head_y) ? int'(occ_y - head_y) : int'(head_y - occ_y);
        hard_rej = (int'(occ_x) >= GRID_W) || (int'(occ_y) >= GRID_H) || occ_hit ||
                   ((occ_x == head_x) && (occ_y == head_y));
        luck_rej = (luck_q == LUCK_UNLUCKY) && ((dx + dy) < 8);
        accept    = (st_q == SP_CHECK) && in_play && !hard_rej && !luck_rej;
        luck_miss = (st_q == SP_CHECK) && in_play && !hard_rej && luck_rej;
        st_d = st_q;
        case (st_q)
            SP_IDLE:  if (spawn_req && in_play) st_d = SP_GEN;
            SP_GEN:   st_d = in_play ? SP_CHECK : SP_IDLE;
            SP_CHECK: st_d = (in_play && (hard_rej || luck_rej)) ? SP_GEN : SP_IDLE;
            default:  st_d = SP_IDLE;
        endcase
    end

    // Control: state, busy/done flags, latched luck and luck-reject counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q       <= SP_IDLE;
            busy       <= 1'b0;
            spawn_done <= 1'b0;
            luck_q     <= LUCK_NORMAL;
            tries_q    <= '0;
        end else begin
            st_q       <= st_d;
            busy       <= (st_d != SP_IDLE);
            spawn_done <= accept;
            if (st_q == SP_IDLE && st_d == SP_GEN) begin
                luck_q  <= (apple_luck == 2'b11) ? LUCK_NORMAL : apple_luck;
                tries_q <= '0;
            end else if (luck_miss) begin
                if (int'(tries_q) < MAX_TRIES)
                    tries_q <= tries_q + 1'b1;
                // Give up on the luck filter once it has starved the search
                if (int'(tries_q) + 1 >= MAX_TRIES)
                    luck_q <= LUCK_NORMAL;
            end
        end
    end

    // Datapath: candidate register toward the body store and committed apple
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ_x       <= 4'd0;
            occ_y       <= 4'd0;
            apple_x     <= INIT_X;
            apple_y     <= INIT_Y;
            apple_valid <= 1'b0;
        end else begin
            if (st_q == SP_GEN && in_play) begin
                occ_x <= cand_x;
                occ_y <= cand_y;
            end
            if (accept) begin
                apple_x     <= occ_x;
                apple_y     <= occ_y;
                apple_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_t06_apple_spawner.sv
// Scoreboard bench for the apple spawner: stimulus pushes expectations,
// a monitor pops and checks them on every spawn_done.
module tb_t06_apple_spawner;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] state, apple_luck;
    logic [3:0] head_x, head_y;
    logic       spawn_req;
    logic [3:0] occ_x, occ_y;
    logic       occ_hit;
    logic [3:0] apple_x, apple_y;
    logic       apple_valid, busy, spawn_done;

    t06_apple_spawner dut (
        .clk(clk), .rst(rst), .state(state), .apple_luck(apple_luck),
        .head_x(head_x), .head_y(head_y), .spawn_req(spawn_req),
        .occ_x(occ_x), .occ_y(occ_y), .occ_hit(occ_hit),
        .apple_x(apple_x), .apple_y(apple_y), .apple_valid(apple_valid),
        .busy(busy), .spawn_done(spawn_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int kind;   // 0 exact, 1 lucky window, 2 unlucky distance
        int x; int y; int lat; int hx; int hy; int rc;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0, errors = 0, done_cnt = 0, cyc = 0;
    logic hit_en;
    int   bx[3], by[3];
    logic [15:0] m_lfsr;

    function automatic logic [15:0] nx(input logic [15:0] s);
        logic [15:0] r;
        r = {1'b0, s[15:1]};
        if (s[0]) r = r ^ 16'hB400;
        return r;
    endfunction

    // Normal-mode candidate n of a search whose GEN cycle sees LFSR value l
    function automatic void cand(input logic [15:0] l, input int n, output int x, output int y);
        logic [15:0] s;
        s = l;
        for (int i = 0; i < 2 * n; i++) s = nx(s);
        x = int'(s[3:0]);
        y = int'(s[7:4]);
    endfunction

    function automatic bit legal(input int x, input int y);
        return (y < 12) && !(x == int'(head_x) && y == int'(head_y));
    endfunction

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk or posedge rst)
        if (rst) m_lfsr <= 16'hACE1; else m_lfsr <= nx(m_lfsr);

    assign occ_hit = hit_en && ((int'(occ_x) == bx[0] && int'(occ_y) == by[0]) ||
                                (int'(occ_x) == bx[1] && int'(occ_y) == by[1]) ||
                                (int'(occ_x) == bx[2] && int'(occ_y) == by[2]));

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Monitor
    exp_t m_e;
    int   m_lat, m_dx, m_dy, m_man;
    always @(negedge clk) begin
        if (!rst && spawn_done === 1'b1) begin
            done_cnt++;
            if (sbq.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                m_e   = sbq.pop_front();
                m_lat = cyc - m_e.rc;
                chk("apple_valid", int'(apple_valid), 1);
                if (m_e.kind == 0) begin
                    chk("apple_x", int'(apple_x), m_e.x);
                    chk("apple_y", int'(apple_y), m_e.y);
                    chk("latency", m_lat, m_e.lat);
                end else if (m_e.kind == 1) begin
                    m_dx = (int'(apple_x) - m_e.hx + 16) % 16;
                    m_dy = (int'(apple_y) - m_e.hy + 12) % 12;
                    chk("lucky_window", int'((apple_y < 4'd12) && (m_dx <= 3 || m_dx >= 12) &&
                        (m_dy <= 3 || m_dy >= 8)), 1);
                end else begin
                    m_dx  = (int'(apple_x) > m_e.hx) ? int'(apple_x) - m_e.hx : m_e.hx - int'(apple_x);
                    m_dy  = (int'(apple_y) > m_e.hy) ? int'(apple_y) - m_e.hy : m_e.hy - int'(apple_y);
                    m_man = m_dx + m_dy;
                    chk("unlucky_dist", int'((apple_y < 4'd12) && (m_man >= 8 || m_lat >= 32)), 1);
                end
            end
        end
    end

    // Called at a negedge; the request is sampled by the next posedge
    task automatic issue(input int kind, input int x, input int y, input int lat);
        exp_t e;
        e.kind = kind; e.x = x; e.y = y; e.lat = lat;
        e.hx = int'(head_x); e.hy = int'(head_y); e.rc = cyc + 1;
        sbq.push_back(e);
        spawn_req = 1'b1;
        @(negedge clk);
        spawn_req = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_pending"}, sbq.size(), 0);
        sbq.delete();
    endtask

    // Predict the normal-mode result (no occupancy) and issue it
    task automatic spawn_normal(input string nm);
        int x, y, lat;
        lat = -1;
        for (int n = 0; n < 64 && lat < 0; n++) begin
            cand(nx(m_lfsr), n, x, y);
            if (legal(x, y)) lat = 2 + 2 * n;
        end
        issue(0, x, y, lat);
        wait_idle(nm);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int x, y, c0x, c0y, c1x, c1y, c2x, c2y, c3x, c3y, a0x, a0y, d0;
        bit found;
        logic [3:0] hxs[4];
        logic [3:0] hys[4];
        hxs = '{4'd5, 4'd0, 4'd15, 4'd3};
        hys = '{4'd5, 4'd11, 4'd0, 4'd7};
        rst = 1'b1; state = 2'b00; apple_luck = 2'b00; head_x = 4'd0; head_y = 4'd0;
        spawn_req = 1'b0; hit_en = 1'b0;
        for (int i = 0; i < 3; i++) begin bx[i] = -1; by[i] = -1; end
        repeat (3) @(negedge clk);
        chk("rst_apple_x", int'(apple_x), 8);
        chk("rst_apple_y", int'(apple_y), 6);
        chk("rst_apple_valid", int'(apple_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(spawn_done), 0);
        chk("rst_occ_x", int'(occ_x), 0);
        chk("rst_occ_y", int'(occ_y), 0);
        rst = 1'b0;
        @(negedge clk);

        // Requests outside play are dropped
        state = 2'b01;
        spawn_req = 1'b1; @(negedge clk); spawn_req = 1'b0; @(negedge clk);
        chk("menu_req_busy", int'(busy), 0);
        chk("menu_req_valid", int'(apple_valid), 0);

        // First candidate legal: done exactly two edges after the request
        state = 2'b10; head_x = 4'd5; head_y = 4'd5;
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            cand(nx(m_lfsr), 0, x, y);
            if (legal(x, y)) found = 1; else @(negedge clk);
        end
        chk("find_legal_slot", int'(found), 1);
        issue(0, x, y, 2);
        wait_idle("first");

        // Normal spawns with assorted heads, including an edge-cell head
        for (int k = 0; k < 4; k++) begin
            head_x = hxs[k]; head_y = hys[k];
            spawn_normal("normal");
        end

        // Luck code 11 behaves as normal
        apple_luck = 2'b11;
        spawn_normal("luck11");
        apple_luck = 2'b00;

        // Body blocks the first three candidates; luck change mid-search ignored
        head_x = 4'd1; head_y = 4'd2;
        found = 0;
        for (int i = 0; i < 2000 && !found; i++) begin
            cand(nx(m_lfsr), 0, c0x, c0y); cand(nx(m_lfsr), 1, c1x, c1y);
            cand(nx(m_lfsr), 2, c2x, c2y); cand(nx(m_lfsr), 3, c3x, c3y);
            if (legal(c0x, c0y) && legal(c1x, c1y) && legal(c2x, c2y) && legal(c3x, c3y) &&
                !(c3x == c0x && c3y == c0y) && !(c3x == c1x && c3y == c1y) &&
                !(c3x == c2x && c3y == c2y))
                found = 1;
            else
                @(negedge clk);
        end
        chk("find_block_slot", int'(found), 1);
        bx[0] = c0x; by[0] = c0y; bx[1] = c1x; by[1] = c1y; bx[2] = c2x; by[2] = c2y;
        hit_en = 1'b1;
        issue(0, c3x, c3y, 8);
        apple_luck = 2'b10;
        wait_idle("blocked");
        hit_en = 1'b0; apple_luck = 2'b00;

        // Second request while busy is dropped
        head_x = 4'd9; head_y = 4'd9;
        d0 = done_cnt;
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            cand(nx(m_lfsr), 0, x, y);
            if (legal(x, y)) found = 1; else @(negedge clk);
        end
        issue(0, x, y, 2);
        spawn_req = 1'b1; @(negedge clk); spawn_req = 1'b0;
        wait_idle("busy_req");
        repeat (8) @(negedge clk);
        chk("busy_req_done_count", done_cnt - d0, 1);

        // Leaving play during CHECK aborts with no commit
        a0x = int'(apple_x); a0y = int'(apple_y); d0 = done_cnt;
        spawn_req = 1'b1; @(negedge clk); spawn_req = 1'b0;
        @(negedge clk);
        state = 2'b11;
        @(negedge clk);
        chk("abort_busy", int'(busy), 0);
        repeat (4) @(negedge clk);
        chk("abort_apple_x", int'(apple_x), a0x);
        chk("abort_apple_y", int'(apple_y), a0y);
        chk("abort_done_count", done_cnt, d0);
        state = 2'b10;
        @(negedge clk);

        // Lucky: apples stay in the wrapped window around the head
        apple_luck = 2'b01; head_x = 4'd0; head_y = 4'd0;
        for (int k = 0; k < 200; k++) begin
            issue(1, 0, 0, 0);
            wait_idle("lucky");
        end

        // Unlucky: far from the head unless the luck filter gave up
        apple_luck = 2'b10; head_x = 4'd8; head_y = 4'd6;
        for (int k = 0; k < 200; k++) begin
            issue(2, 0, 0, 0);
            wait_idle("unlucky");
        end

        repeat (4) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
